// File: rtl/ofmap_wb.sv
// ofmap_wb: packs upper/lower half-word results into full words and queues them as memory writes.
// Ports: ck/rst (async active-low) clock and reset; clear synchronous flush;
//   i_wr/i_wrh_l_n/i_ev_odd_n/i_even_addr/i_odd_addr/i_data half-word write from the datapath;
//   m_valid/m_ready/m_bank/m_addr/m_data memory write request from the queue head;
//   o_busy/o_full status; o_err_order/o_err_addr/o_err_ovf sticky errors; o_wcnt saturating write count.
module ofmap_wb #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 i_wr,
  input  logic                 i_wrh_l_n,
  input  logic                 i_ev_odd_n,
  input  logic [AW-1:0]        i_even_addr,
  input  logic [AW-1:0]        i_odd_addr,
  input  logic [N*(W/2)-1:0]   i_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_bank,
  output logic [AW-1:0]        m_addr,
  output logic [4*W-1:0]       m_data,
  output logic                 o_busy,
  output logic                 o_full,
  output logic                 o_err_order,
  output logic                 o_err_addr,
  output logic                 o_err_ovf,
  output logic [15:0]          o_wcnt
);
  localparam int HW = N*(W/2);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nx;
  logic [HW-1:0] held;
  logic held_bank;
  logic [AW-1:0] held_addr;
  logic [AW-1:0] addr;
  logic [AW+2*HW:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] count;
  logic capture, push_req, set_order, set_addr, pop, push, ovf;
  assign addr = i_ev_odd_n ? i_odd_addr : i_even_addr;
  always_comb begin
    state_nx  = state;
    capture   = 1'b0;
    push_req  = 1'b0;
    set_order = 1'b0;
    set_addr  = 1'b0;
    if (i_wr) begin
      if (state == IDLE) begin
        capture   = !i_wrh_l_n;
        set_order = i_wrh_l_n;
        state_nx  = i_wrh_l_n ? IDLE : HOLD;
      end else if (!i_wrh_l_n) begin
        capture   = 1'b1;
        set_order = 1'b1;
      end else begin
        state_nx  = IDLE;
        push_req  = (i_ev_odd_n == held_bank) && (addr == held_addr);
        set_addr  = !push_req;
      end
    end
  end
  assign m_valid = count != '0;
  assign o_full  = count == DEPTH_C;
  assign o_busy  = (state == HOLD) || m_valid;
  assign pop     = m_valid && m_ready && !clear;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push    = push_req && (!o_full || pop) && !clear;
  assign ovf     = push_req && o_full && !pop && !clear;
  // Head fields are gated so they read zero whenever nothing is queued.
  assign {m_bank, m_addr, m_data} = m_valid ? mem[rp] : '0;
  always_ff @(posedge ck) begin
    if (push) mem[wp] <= {i_ev_odd_n, addr, held, i_data};
  end
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      held        <= '0;
      held_bank   <= 1'b0;
      held_addr   <= '0;
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      o_err_order <= 1'b0;
      o_err_addr  <= 1'b0;
      o_err_ovf   <= 1'b0;
      o_wcnt      <= '0;
    end else if (clear) begin
      state       <= IDLE;
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      o_err_order <= 1'b0;
      o_err_addr  <= 1'b0;
      o_err_ovf   <= 1'b0;
      o_wcnt      <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        held      <= i_data;
        held_bank <= i_ev_odd_n;
        held_addr <= addr;
      end
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (set_order) o_err_order <= 1'b1;
      if (set_addr) o_err_addr <= 1'b1;
      if (ovf) o_err_ovf <= 1'b1;
      if (pop && o_wcnt != 16'hFFFF) o_wcnt <= o_wcnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_ofmap_wb.sv
// tb_ofmap_wb: directed self-checking bench for ofmap_wb.
module tb_ofmap_wb;
  logic ck = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic i_wr = 1'b0;
  logic i_wrh_l_n = 1'b0;
  logic i_ev_odd_n = 1'b0;
  logic [9:0] i_even_addr = '0;
  logic [9:0] i_odd_addr = '0;
  logic [15:0] i_data = '0;
  logic m_valid, m_ready, m_bank;
  logic [9:0] m_addr;
  logic [31:0] m_data;
  logic o_busy, o_full, o_err_order, o_err_addr, o_err_ovf;
  logic [15:0] o_wcnt;
  int tests = 0;
  int fails = 0;

  ofmap_wb dut (
    .ck(ck), .rst(rst), .clear(clear), .i_wr(i_wr), .i_wrh_l_n(i_wrh_l_n),
    .i_ev_odd_n(i_ev_odd_n), .i_even_addr(i_even_addr), .i_odd_addr(i_odd_addr),
    .i_data(i_data), .m_valid(m_valid), .m_ready(m_ready), .m_bank(m_bank),
    .m_addr(m_addr), .m_data(m_data), .o_busy(o_busy), .o_full(o_full),
    .o_err_order(o_err_order), .o_err_addr(o_err_addr), .o_err_ovf(o_err_ovf),
    .o_wcnt(o_wcnt)
  );

  always #5 ck = ~ck;

  // Called at a falling edge; drives one half-word for one rising edge and returns at the next falling edge.
  task automatic half(input bit lo, input bit odd, input logic [9:0] a, input logic [15:0] d);
    i_wr = 1'b1;
    i_wrh_l_n = lo;
    i_ev_odd_n = odd;
    i_odd_addr = odd ? a : 10'h3FF;
    i_even_addr = odd ? 10'h3FF : a;
    i_data = d;
    @(negedge ck);
    i_wr = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge ck);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    m_ready = 1'b0;
    #2;
    tests++;
    if ({m_valid, m_bank, m_addr, m_data} !== 44'h0) begin
      fails++;
      $display("FAIL reset_head got %b %h %h %h want 0", m_valid, m_bank, m_addr, m_data);
    end
    tests++;
    if ({o_busy, o_full, o_err_order, o_err_addr, o_err_ovf, o_wcnt} !== 21'h0) begin
      fails++;
      $display("FAIL reset_status got %b%b%b%b%b %h want 0", o_busy, o_full, o_err_order, o_err_addr, o_err_ovf, o_wcnt);
    end
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
  endtask

  task automatic test_pair();
    m_ready = 1'b1;
    half(0, 1, 10'd5, 16'hA1B2);
    tests++;
    if (o_busy !== 1'b1 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL pair_hold got busy=%b valid=%b want busy=1 valid=0", o_busy, m_valid);
    end
    half(1, 1, 10'd5, 16'hC3D4);
    tests++;
    if ({m_valid, m_bank, m_addr, m_data} !== {1'b1, 1'b1, 10'd5, 32'hA1B2C3D4}) begin
      fails++;
      $display("FAIL pair_word got %b %b %h %h want 1 1 005 a1b2c3d4", m_valid, m_bank, m_addr, m_data);
    end
    @(negedge ck);
    tests++;
    if (o_wcnt !== 16'd1 || m_valid !== 1'b0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL pair_count got wcnt=%0d valid=%b busy=%b want 1 0 0", o_wcnt, m_valid, o_busy);
    end
  endtask

  task automatic test_backpressure();
    do_clear();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      half(0, 0, 10'(i), 16'h1000 + 16'(i));
      half(1, 0, 10'(i), 16'h2000 + 16'(i));
      if (i == 3) begin
        tests++;
        if (o_full !== 1'b1 || o_err_ovf !== 1'b0) begin
          fails++;
          $display("FAIL bp_full got full=%b ovf=%b want 1 0", o_full, o_err_ovf);
        end
      end
    end
    tests++;
    if (o_err_ovf !== 1'b1 || o_full !== 1'b1) begin
      fails++;
      $display("FAIL bp_ovf got ovf=%b full=%b want 1 1", o_err_ovf, o_full);
    end
    tests++;
    if (m_addr !== 10'd0 || m_data !== 32'h10002000 || m_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_stable got %b %h %h want 1 000 10002000", m_valid, m_addr, m_data);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (m_valid !== 1'b1 || m_addr !== 10'(i) || m_data !== {16'h1000 + 16'(i), 16'h2000 + 16'(i)}) begin
        fails++;
        $display("FAIL bp_drain%0d got %b %h %h want 1 %h %h%h", i, m_valid, m_addr, m_data, 10'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(i));
      end
      @(negedge ck);
    end
    tests++;
    if (m_valid !== 1'b0 || o_wcnt !== 16'd4) begin
      fails++;
      $display("FAIL bp_done got valid=%b wcnt=%0d want 0 4", m_valid, o_wcnt);
    end
  endtask

  task automatic test_order();
    do_clear();
    m_ready = 1'b1;
    half(1, 1, 10'd9, 16'hFFFF);
    tests++;
    if (o_err_order !== 1'b1 || m_valid !== 1'b0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL order_lone got err=%b valid=%b busy=%b want 1 0 0", o_err_order, m_valid, o_busy);
    end
    half(0, 1, 10'd7, 16'h1111);
    half(0, 1, 10'd7, 16'h2222);
    half(1, 1, 10'd7, 16'h3333);
    tests++;
    if (m_valid !== 1'b1 || m_addr !== 10'd7 || m_data !== 32'h22223333) begin
      fails++;
      $display("FAIL order_replace got %b %h %h want 1 007 22223333", m_valid, m_addr, m_data);
    end
    @(negedge ck);
  endtask

  task automatic test_mismatch();
    do_clear();
    m_ready = 1'b1;
    half(0, 0, 10'd3, 16'hAAAA);
    half(1, 0, 10'd4, 16'hBBBB);
    tests++;
    if (o_err_addr !== 1'b1 || o_err_order !== 1'b0 || m_valid !== 1'b0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL mismatch got addr=%b order=%b valid=%b busy=%b want 1 0 0 0", o_err_addr, o_err_order, m_valid, o_busy);
    end
    half(0, 0, 10'd6, 16'h0102);
    half(1, 0, 10'd6, 16'h0304);
    tests++;
    if (m_valid !== 1'b1 || m_bank !== 1'b0 || m_data !== 32'h01020304) begin
      fails++;
      $display("FAIL mismatch_recover got %b %b %h want 1 0 01020304", m_valid, m_bank, m_data);
    end
    @(negedge ck);
  endtask

  task automatic test_full_pop();
    do_clear();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      half(0, 1, 10'(i), 16'h5000 + 16'(i));
      half(1, 1, 10'(i), 16'h6000 + 16'(i));
    end
    half(0, 1, 10'd8, 16'h7777);
    m_ready = 1'b1;
    half(1, 1, 10'd8, 16'h8888);
    m_ready = 1'b0;
    tests++;
    if (o_err_ovf !== 1'b0 || o_full !== 1'b1 || m_addr !== 10'd1 || o_wcnt !== 16'd1) begin
      fails++;
      $display("FAIL full_pop got ovf=%b full=%b addr=%h wcnt=%0d want 0 1 001 1", o_err_ovf, o_full, m_addr, o_wcnt);
    end
    m_ready = 1'b1;
    repeat (3) @(negedge ck);
    tests++;
    if (m_addr !== 10'd8 || m_data !== 32'h77778888 || o_full !== 1'b0) begin
      fails++;
      $display("FAIL full_pop_tail got addr=%h data=%h full=%b want 008 77778888 0", m_addr, m_data, o_full);
    end
    @(negedge ck);
  endtask

  task automatic test_reset_mid();
    do_clear();
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      half(0, 0, 10'(i), 16'h9000);
      half(1, 0, 10'(i), 16'h9001);
    end
    half(0, 0, 10'd2, 16'h9002);
    rst = 1'b0;
    #1;
    tests++;
    if (m_valid !== 1'b0 || o_busy !== 1'b0 || m_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid got valid=%b busy=%b data=%h want 0 0 0", m_valid, o_busy, m_data);
    end
    @(negedge ck);
    rst = 1'b1;
    m_ready = 1'b1;
    half(1, 0, 10'd2, 16'h9003);
    tests++;
    if (m_valid !== 1'b0 || o_err_order !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_drop got valid=%b order=%b want 0 1", m_valid, o_err_order);
    end
    half(0, 1, 10'd12, 16'hDEAD);
    half(1, 1, 10'd12, 16'hBEEF);
    tests++;
    if (m_valid !== 1'b1 || m_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL reset_mid_new got valid=%b data=%h want 1 deadbeef", m_valid, m_data);
    end
    @(negedge ck);
    tests++;
    if (o_wcnt !== 16'd1) begin
      fails++;
      $display("FAIL reset_mid_cnt got %0d want 1", o_wcnt);
    end
    m_ready = 1'b0;
    half(0, 1, 10'd1, 16'h4444);
    half(1, 1, 10'd1, 16'h5555);
    half(0, 1, 10'd2, 16'h6666);
    clear = 1'b1;
    half(1, 1, 10'd2, 16'h7777);
    clear = 1'b0;
    tests++;
    if ({m_valid, o_busy, o_full, o_err_order, o_err_addr, o_err_ovf, o_wcnt} !== 22'h0) begin
      fails++;
      $display("FAIL clear_wr got %b%b%b%b%b%b %h want 0", m_valid, o_busy, o_full, o_err_order, o_err_addr, o_err_ovf, o_wcnt);
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_backpressure();
    test_order();
    test_mismatch();
    test_full_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
